// File: rtl/tff_pkg.sv
// Shared definitions for the toggle flip-flop sequencing controller:
// state encoding and the carry/borrow toggle-vector helper.
package tff_pkg;

    // Widest bank the helper function handles; callers zero-extend q.
    localparam int MAX_W = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_CLR  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_RUN  = ST_RUN,
        S_HOLD = ST_HOLD,
        S_DONE = ST_DONE,
        S_CLR  = ST_CLR
    } state_t;

    // Toggle enables that move q by one: bit i toggles when every lower bit
    // is 1 (increment carry) or every lower bit is 0 (decrement borrow).
    function automatic logic [MAX_W-1:0] tvec_count(input logic [MAX_W-1:0] q,
                                                    input logic up);
        logic [MAX_W-1:0] t;
        logic             chain;
        t     = '0;
        chain = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            t[i]  = chain;
            chain = chain & (up ? q[i] : ~q[i]);
        end
        return t;
    endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH toggle flip-flops: each bit inverts on a clock edge when its
// T enable is high, and clears on synchronous reset.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    // T flip-flop storage: q toggles where t is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/tff_seq_ctrl.sv
// Sequencing controller for a toggle flip-flop bank: loads a start value,
// counts up or down to a captured limit with pause/abort, and signals
// completion (done) and roll-over (wrap) as single-cycle pulses.
module tff_seq_ctrl
    import tff_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             up,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_t           state;
    state_t           state_nxt;
    logic             up_r;
    logic [WIDTH-1:0] load_r;
    logic [WIDTH-1:0] limit_r;
    logic             wrap_r;
    logic             count_en;
    logic [MAX_W-1:0] q_ext;
    logic [MAX_W-1:0] count_full;
    logic             unused_count_hi;

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk   (clk),
        .reset (reset),
        .t     (t_vec),
        .q     (q)
    );

    // Zero-extend q for the shared helper and take the count toggle vector.
    always_comb begin
        q_ext              = '0;
        q_ext[WIDTH-1:0]   = q;
        count_full         = tvec_count(q_ext, up_r);
    end

    // Bits above WIDTH are don't-care carries from the zero-extension.
    assign unused_count_hi = ^count_full;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and toggle enables; abort beats terminal test beats pause.
    always_comb begin
        state_nxt = state;
        t_vec     = '0;
        count_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (abort) begin
                    state_nxt = S_CLR;
                end else begin
                    t_vec     = q ^ load_r;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_CLR;
                end else if (q == limit_r) begin
                    state_nxt = S_DONE;
                end else if (pause) begin
                    state_nxt = S_HOLD;
                end else begin
                    t_vec    = count_full[WIDTH-1:0];
                    count_en = 1'b1;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_nxt = S_CLR;
                end else if (!pause) begin
                    state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                state_nxt = abort ? S_CLR : S_IDLE;
            end
            S_CLR: begin
                t_vec     = q;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture direction, load value and limit when a start is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_r    <= 1'b0;
            load_r  <= '0;
            limit_r <= '0;
        end else if (state == S_IDLE && start) begin
            up_r    <= up;
            load_r  <= load_val;
            limit_r <= limit;
        end
    end

    // Flag roll-over on the cycle after a counting step leaves the end value.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= count_en && (up_r ? (&q) : ~(|q));
        end
    end

    assign wrap = wrap_r;
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE) && !abort;

endmodule
